// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time and hands it to the core.
// Optional same-cycle response forwarding to the core is enabled with `define IFU_BYPASS_EN.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h8000_0000,
    parameter bit          FAULT_STICKY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic [31:0] next_pc,
    output logic        fetch_fault,
    output logic [31:0] fetch_cnt
);

    // Handshakes: a transfer happens on a cycle where both valid and ready are high;
    // valid and its payload stay stable until that cycle, ready may change freely.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        retire;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        cnt_d     = cnt_q;
        retire    = 1'b0;
        case (state_q)
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    if (mem_rsp_err) begin
                        state_d = S_FAULT;
                    end else begin
                        inst_d    = mem_rsp_data;
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
`ifdef IFU_BYPASS_EN
                        retire    = inst_ready;
`endif
                    end
                end
            end
            S_HOLD: begin
                retire = inst_ready;
            end
            S_FAULT: begin
                if (!FAULT_STICKY) begin
                    pc_d    = RESET_PC;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
        // A misaligned target from the core cannot be fetched and is reported as a fault.
        if (retire) begin
            cnt_d   = cnt_q + 32'd1;
            pc_d    = next_pc;
            state_d = (next_pc[1:0] != 2'b00) ? S_FAULT : S_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
            cnt_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    // Request is masked during reset so memory never sees one while rst is high.
    assign mem_req_valid = (state_q == S_REQ) && !rst;
    assign mem_req_addr  = pc_q;
    assign fetch_fault   = (state_q == S_FAULT);
    assign fetch_cnt     = cnt_q;

`ifdef IFU_BYPASS_EN
    assign inst_valid = (state_q == S_HOLD) ||
                        ((state_q == S_WAIT) && mem_rsp_valid && !mem_rsp_err);
    assign inst       = (state_q == S_WAIT) ? mem_rsp_data : inst_q;
    assign inst_pc    = (state_q == S_WAIT) ? pc_q : inst_pc_q;
`else
    assign inst_valid = (state_q == S_HOLD);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
`endif

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit sitting directly upstream of the single-cycle core.
- Owns the architectural PC.
- Issues word fetches to instruction memory over a valid/ready request channel plus a valid response channel.
- Presents one instruction at a time to the core with a valid/ready handshake.
- Takes the core's computed next_pc when the core accepts the instruction.

Parameters:
RESET_PC, 32'h80000000, PC loaded on reset and first fetch address
FAULT_STICKY, 1, 1 = fault state held until reset; 0 = fault reported for one cycle, then fetch resumes at RESET_PC

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  fetch address (equals pc)
mem_rsp_valid  in  1  fetch data valid
mem_rsp_data  in  32  fetched instruction word
mem_rsp_err  in  1  access fault, qualified by mem_rsp_valid
inst_valid  out  1  inst/inst_pc valid to core
inst_ready  in  1  core consumes instruction this cycle
inst  out  32  instruction to core
inst_pc  out  32  PC of inst
next_pc  in  32  core's next PC, sampled on inst handshake
fetch_fault  out  1  fetch fault indication
fetch_cnt  out  32  count of instructions handed to core

Behaviour:
- Clock/reset decided: one clock clk; rst synchronous and active-high.
- Reset values: state=S_REQ, pc=RESET_PC, inst=0, inst_pc=0, inst_valid=0, fetch_fault=0, fetch_cnt=0, mem_req_valid=0 while rst high.
- States S_REQ, S_WAIT, S_HOLD, S_FAULT. All outputs are registered or decoded from state only (no input-to-output paths, except under the macro below).
- S_REQ:
  - mem_req_valid=1, mem_req_addr=pc; addr held stable until accepted.
  - mem_req_valid&mem_req_ready -> S_WAIT.
  - mem_rsp_valid in S_REQ is ignored.
- S_WAIT:
  - mem_req_valid=0.
  - On mem_rsp_valid&!mem_rsp_err: inst<=mem_rsp_data, inst_pc<=pc, -> S_HOLD.
  - On mem_rsp_valid&mem_rsp_err: -> S_FAULT.
  - Waits indefinitely otherwise.
- S_HOLD:
  - inst_valid=1; inst/inst_pc stable until handshake.
  - On inst_ready: fetch_cnt<=fetch_cnt+1 (wraps 0xFFFFFFFF->0), pc<=next_pc.
  - If next_pc[1:0]!=0 -> S_FAULT, else -> S_REQ.
- S_FAULT:
  - fetch_fault=1, inst_valid=0, mem_req_valid=0.
  - FAULT_STICKY=1: stay until rst.
  - FAULT_STICKY=0: one cycle, then pc<=RESET_PC and -> S_REQ.
- Latency: request accepted cycle N, response N+1 -> inst_valid N+2; with inst_ready at N+2, next request at N+3. Minimum 3 cycles per instruction.
- Only one outstanding request at a time; memory must respond at least one cycle after accept.
- Reset mid-operation: any outstanding request is abandoned and the memory side must drop it on the same rst. The first cycle after rst deasserts issues a request at RESET_PC.
- ebreak and other decode remain in the core; this block passes words unmodified.

Optional Feature:
IFU_BYPASS_EN
- Defined:
  - In S_WAIT, inst_valid=mem_rsp_valid&!mem_rsp_err, inst=mem_rsp_data (combinational), inst_pc=pc.
  - If inst_ready is high the same cycle: handshake completes, pc<=next_pc, -> S_REQ directly (2 cycles/inst minimum).
  - Otherwise data is captured and -> S_HOLD as normal.
- Undefined: behaviour exactly as above, fully registered outputs, 3 cycles/inst.

Test Plan:
- Reset release, mem_req_ready=1, rsp 1 cycle later with data 0x00100093 -> mem_req_addr=0x80000000; inst_valid on cycle N+2 with inst=0x00100093, inst_pc=0x80000000.
- Core accepts with next_pc=0x80000004 -> next mem_req_addr=0x80000004, fetch_cnt=1; hold inst_ready=0 for 5 cycles -> inst/inst_pc unchanged, no new request.
- mem_req_ready low 4 cycles -> mem_req_valid stays 1, addr stable at pc; rsp_valid pulsed in S_REQ ignored.
- mem_rsp_err=1 on response -> fetch_fault=1, inst_valid=0; sticky until rst (FAULT_STICKY=1); with FAULT_STICKY=0, next request at 0x80000000.
- next_pc=0x80000006 at handshake -> S_FAULT, fetch_fault=1, no request issued.
- rst asserted in S_WAIT -> next cycle after release mem_req_addr=0x80000000, fetch_cnt=0; with IFU_BYPASS_EN, rsp and inst_ready in the same cycle -> next request one cycle later.
